// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC    = 32'h0;
  localparam logic [3:0]  DEF_HALT_OPCODE = 4'hF;

  // Extract a w-bit field whose MSB sits at bit msb.
  function automatic logic [63:0] op_field(input logic [63:0] instr, input int msb, input int w);
    return (instr >> (msb - w + 1)) & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/instr_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr}; head is read straight from registers.
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             _clock,
  input  logic             _reset_n,
  input  logic             _push,
  input  logic             _pop,
  input  logic             _flush,
  input  logic [AW-1:0]    _push_pc,
  input  logic [DW-1:0]    _push_instr,
  output logic             _valid,
  output logic [AW-1:0]    _head_pc,
  output logic [DW-1:0]    _head_instr,
  output logic [CNT_W-1:0] _count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][AW-1:0] pc_mem;
  logic [DEPTH-1:0][DW-1:0] instr_mem;
  logic [PTR_W-1:0]         rd_ptr, wr_ptr;
  logic [CNT_W-1:0]         cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Push into a full FIFO is only ever paired with a pop, so the write
  // slot equals the slot being vacated this edge.
  always_ff @(posedge _clock) begin
    if (!_reset_n || _flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (_push) begin
        pc_mem[wr_ptr]    <= _push_pc;
        instr_mem[wr_ptr] <= _push_instr;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({_push, _pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign _valid      = (cnt != '0);
  assign _head_pc    = pc_mem[rd_ptr];
  assign _head_instr = instr_mem[rd_ptr];
  assign _count      = cnt;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited reads, buffers words
// for decode, and handles redirect flushes and halt draining.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                INSTR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC),
  parameter int                DEPTH       = 2,
  parameter int                OP_MSB      = 31,
  parameter int                OP_W        = 4,
  parameter logic [OP_W-1:0]   HALT_OPCODE = OP_W'(DEF_HALT_OPCODE)
) (
  input  logic               _clock,
  input  logic               _reset_n,
  output logic               _mem_req,
  output logic [ADDR_W-1:0]  _mem_addr,
  input  logic [INSTR_W-1:0] _mem_instr,
  input  logic               _redirect,
  input  logic [ADDR_W-1:0]  _redirect_pc,
  output logic [INSTR_W-1:0] _instr,
  output logic [ADDR_W-1:0]  _instr_pc,
  output logic               _instr_valid,
  input  logic               _instr_ready,
  output logic               _halted,
  output logic [ADDR_W-1:0]  _pc
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e       state, state_nxt;
  logic [ADDR_W-1:0]  pc_q, addr_prev;
  logic               inflight;
  logic [CNT_W-1:0]   count;
  logic               fifo_valid;
  logic [ADDR_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic [CNT_W:0]     credit;
  logic               redir, pop, push, req, halt_push, halt_pop;

  // A halted unit ignores redirects entirely.
  assign redir  = _redirect & (state != ST_HALTED);
  assign pop    = _instr_valid & _instr_ready & ~_redirect;
  assign credit = (CNT_W+1)'(count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign req    = (state == ST_RUN) & ~_redirect & _reset_n & (credit < (CNT_W+1)'(DEPTH));

  // Responses are dropped once draining or when a redirect kills them.
  assign push      = inflight & ~redir & (state == ST_RUN);
  assign halt_push = push &
                     (op_field(64'(_mem_instr), OP_MSB, OP_W) == 64'(HALT_OPCODE));
  assign halt_pop  = pop & (state == ST_DRAIN) &
                     (op_field(64'(head_instr), OP_MSB, OP_W) == 64'(HALT_OPCODE));

  always_ff @(posedge _clock) begin
    if (!_reset_n) state <= ST_RUN;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (halt_push) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (redir) state_nxt = ST_RUN;
                 else if (halt_pop) state_nxt = ST_HALTED;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge _clock) begin
    if (!_reset_n) begin
      pc_q      <= RESET_PC;
      addr_prev <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= req;
      if (req) addr_prev <= pc_q;
      if (redir)    pc_q <= _redirect_pc;
      else if (req) pc_q <= pc_q + ADDR_W'(1);
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .AW    (ADDR_W),
    .DW    (INSTR_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    ._clock      (_clock),
    ._reset_n    (_reset_n),
    ._push       (push),
    ._pop        (pop),
    ._flush      (redir),
    ._push_pc    (addr_prev),
    ._push_instr (_mem_instr),
    ._valid      (fifo_valid),
    ._head_pc    (head_pc),
    ._head_instr (head_instr),
    ._count      (count)
  );

  assign _mem_req     = req;
  assign _mem_addr    = pc_q;
  assign _pc          = pc_q;
  assign _instr       = head_instr;
  assign _instr_pc    = head_pc;
  assign _instr_valid = fifo_valid & (state != ST_HALTED);
  assign _halted      = (state == ST_HALTED);
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control/decode block.
- Owns the program counter and issues word-addressed reads to the instruction port of the memory.
- Buffers returned words with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects (flush) and stops fetching after a halt instruction.

Parameters:
- ADDR_W, 32, width of PC and memory address
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC loaded on reset
- DEPTH, 2, FIFO entries (credit limit on outstanding plus buffered words)
- OP_MSB, 31, MSB of opcode field in instruction
- OP_W, 4, opcode field width
- HALT_OPCODE, 4'hF, opcode that terminates fetching

Ports:
- _clock  in  1  single clock, all state on rising edge
- _reset_n  in  1  synchronous, active-low reset
- _mem_req  out  1  read request to memory instruction port
- _mem_addr  out  ADDR_W  read address (word address)
- _mem_instr  in  INSTR_W  read data, valid exactly 1 cycle after the _mem_req cycle
- _redirect  in  1  flush and restart fetch at _redirect_pc
- _redirect_pc  in  ADDR_W  redirect target
- _instr  out  INSTR_W  instruction at FIFO head
- _instr_pc  out  ADDR_W  PC of _instr
- _instr_valid  out  1  FIFO head valid
- _instr_ready  in  1  decode accepts head
- _halted  out  1  halt instruction consumed; fetch stopped
- _pc  out  ADDR_W  next fetch PC (debug)

Behaviour:
- Reset (sampled low at an edge):
  - _pc=RESET_PC, FIFO empty, inflight=0, state=RUN.
  - _instr_valid=0, _halted=0, _mem_req=0 during reset.
  - A response to a request issued before reset is discarded.
- pop = _instr_valid & _instr_ready & ~_redirect.
- _mem_req is combinational: asserted when state==RUN, ~_redirect, _reset_n high, and (occupancy + inflight − pop) < DEPTH.
- _mem_addr = _pc.
- On a request: _pc <= _pc+1 (modulo 2^ADDR_W; 0xFFFFFFFF wraps to 0), inflight <= 1.
- Response: in the cycle after a request, if not killed, push {_mem_addr_prev, _mem_instr} into the FIFO.
- Latency: request in cycle N → _instr_valid in cycle N+2.
- Throughput: sustains 1 instruction/cycle with _instr_ready held high.
- Outputs _instr/_instr_pc/_instr_valid come from registered FIFO state.
- They hold stable while _instr_valid & ~_instr_ready.
- Push and pop in the same cycle are legal at any occupancy. The credit rule guarantees no overflow, so the FIFO never drops data.
- Redirect (highest priority, any state except HALTED):
  - FIFO flushed and inflight response killed.
  - _pc <= _redirect_pc; state <= RUN.
  - No pop is counted that cycle.
  - First request at _redirect_pc is issued the following cycle.
- Halt:
  - When a pushed word has opcode field [OP_MSB -: OP_W] == HALT_OPCODE, state RUN→DRAIN.
  - That word is pushed normally.
  - No further requests are issued; any later response is discarded.
- DRAIN→HALTED when the halt word is popped. _halted=1 from the next cycle, _instr_valid=0.
- A redirect in DRAIN flushes and returns to RUN; the halt is cancelled.
- HALTED is absorbing; only reset leaves it. _redirect is ignored.
- _redirect and reset asserted together: reset wins.

Decomposition:
- Package fetch_pkg: state enum {RUN, DRAIN, HALTED}, defaults for RESET_PC/HALT_OPCODE, opcode-field extraction function.
- One sub-module, instr_fifo: DEPTH-entry synchronous FIFO of {pc, instr}, with push, pop, flush, and occupancy count.

Test Plan:
- Reset release, _instr_ready=1, memory returns mem[a]=a+0x100 → requests at 0,1,2… on consecutive cycles. First _instr_valid is 2 cycles after first _mem_req with _instr=0x100, _instr_pc=0, then one instruction per cycle.
- _instr_ready=0 for 5 cycles after the first valid → exactly 2 words buffered, _mem_req low. _instr (0x100) stable. On ready: 0x100 then 0x101 delivered with no gaps or duplicates.
- _redirect=1, _redirect_pc=0x40 while FIFO full and one inflight → next cycle _instr_valid=0, _mem_addr=0x40. Next delivered _instr_pc=0x40; stale words never appear.
- Word at PC 3 has opcode 4'hF → fetch stops after PC 3; PC 0–3 delivered. _halted=1 the cycle after PC 3 pops; no later _mem_req.
- Redirect to 0x10 while the halt word sits unconsumed in the FIFO → halt cancelled, fetch resumes at 0x10, _halted stays 0.
- RESET_PC=0xFFFFFFFF → addresses 0xFFFFFFFF, 0x0, 0x1. Reset mid-stream (inflight=1) → first post-reset delivered _instr_pc=RESET_PC.
